gestor_motores: RTL and testbench

GESTOR_MOTORES -- requirements
Module: gestor_motores

---
 rtl/gestor_motores.sv | 156 +++++++++++++++
 tb/tb_gestor_motores.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gestor_motores.sv
// gestor_motores: manages a hybrid drive with an electric motor (battery) and
// a gas motor (tank).
//
// The block runs on the preferred source until it is empty and then falls
// back to the other source. Battery regeneration happens while the gas motor
// runs. When both sources are empty the block waits for a recharge/refuel.
//
// Ports:
//   CLK        - single clock, rising-edge active
//   REINICIO   - asynchronous active-high reset
//   ARRANQUE   - start request (only looked at in REPOSO)
//   MODO       - preferred source: 0 = electric, 1 = gas
//   PARO       - stop request (only looked at in ELECTRICO and GAS)
//   CARGA_REQ  - recharge/refuel request (level signal)
//   MOTOR1     - electric motor enable
//   MOTOR2     - gas motor enable
//   CARGA_ACK  - charge in progress
//   AGOTADO    - both sources empty
//   NIVEL_BAT  - battery level, 0..BAT_MAX
//   NIVEL_TQ   - tank level, 0..TQ_MAX
//   ESTADO     - state code, exposed for debug and checkers
//
// Charge handshake: CARGA_REQ is a level request, not a pulse. CARGA_ACK is
// high for every cycle the block spends charging. Dropping CARGA_REQ ends the
// charge on the next edge, and that edge adds no charge. Charging also ends by
// itself on the edge where both levels reach full. A request held high after
// that does not start a new charge while both levels are full.
module gestor_motores #(
  parameter int BAT_MAX = 20,
  parameter int TQ_MAX  = 15,
  parameter int W       = 6
) (
  input  logic         CLK,
  input  logic         REINICIO,
  input  logic         ARRANQUE,
  input  logic         MODO,
  input  logic         PARO,
  input  logic         CARGA_REQ,
  output logic         MOTOR1,
  output logic         MOTOR2,
  output logic         CARGA_ACK,
  output logic         AGOTADO,
  output logic [W-1:0] NIVEL_BAT,
  output logic [W-1:0] NIVEL_TQ,
  output logic [2:0]   ESTADO
);

  typedef enum logic [2:0] {
    S_REPOSO    = 3'd0,
    S_ELECTRICO = 3'd1,
    S_GAS       = 3'd2,
    S_CARGA     = 3'd3,
    S_AGOTADO   = 3'd4
  } state_t;

  localparam logic [W-1:0] BAT_FULL = W'(BAT_MAX);
  localparam logic [W-1:0] TQ_FULL  = W'(TQ_MAX);
  localparam logic [W-1:0] ONE      = W'(1);

  state_t       st, st_n;
  logic [W-1:0] bat, bat_n, tq, tq_n;
  logic [1:0]   regen, regen_n;

  logic         bat_full, tq_full, bat_empty, tq_empty;
  logic [W-1:0] bat_inc, tq_inc;

  assign bat_full  = (bat == BAT_FULL);
  assign tq_full   = (tq == TQ_FULL);
  assign bat_empty = (bat == '0);
  assign tq_empty  = (tq == '0);
  // Saturating increments. They are shared by charging and regeneration.
  assign bat_inc   = bat_full ? bat : bat + ONE;
  assign tq_inc    = tq_full ? tq : tq + ONE;

  always_ff @(posedge CLK or posedge REINICIO) begin
    if (REINICIO) begin
      st    <= S_REPOSO;
      bat   <= BAT_FULL;
      tq    <= TQ_FULL;
      regen <= 2'd0;
    end else begin
      st    <= st_n;
      bat   <= bat_n;
      tq    <= tq_n;
      regen <= regen_n;
    end
  end

  always_comb begin
    st_n    = st;
    bat_n   = bat;
    tq_n    = tq;
    regen_n = 2'd0;
    case (st)
      S_REPOSO: begin
        if (CARGA_REQ && !(bat_full && tq_full)) begin
          st_n = S_CARGA;
        end else if (ARRANQUE) begin
          if (!MODO) begin
            if (!bat_empty)     st_n = S_ELECTRICO;
            else if (!tq_empty) st_n = S_GAS;
            else                st_n = S_AGOTADO;
          end else begin
            if (!tq_empty)       st_n = S_GAS;
            else if (!bat_empty) st_n = S_ELECTRICO;
            else                 st_n = S_AGOTADO;
          end
        end
      end
      S_ELECTRICO: begin
        if (PARO)            st_n  = S_REPOSO;
        else if (!bat_empty) bat_n = bat - ONE;
        else                 st_n  = tq_empty ? S_AGOTADO : S_GAS;
      end
      S_GAS: begin
        if (PARO) begin
          st_n = S_REPOSO;
        end else begin
          // Every running gas cycle counts toward regeneration, and so does
          // the cycle that leaves on an empty tank. One battery unit is
          // added every fourth cycle.
          regen_n = regen + 2'd1;
          if (regen == 2'd3) bat_n = bat_inc;
          if (!tq_empty) tq_n = tq - ONE;
          // The fallback decision uses the registered battery level, so any
          // regeneration credited on this same edge is not taken into account.
          else           st_n = bat_empty ? S_AGOTADO : S_ELECTRICO;
        end
      end
      S_CARGA: begin
        if (!CARGA_REQ) begin
          st_n = S_REPOSO;
        end else begin
          bat_n = bat_inc;
          tq_n  = tq_inc;
          // Leave on the edge that fills both, so no idle full cycle occurs.
          if (bat_inc == BAT_FULL && tq_inc == TQ_FULL) st_n = S_REPOSO;
        end
      end
      S_AGOTADO: begin
        if (CARGA_REQ) st_n = S_CARGA;
      end
      default: st_n = S_REPOSO;
    endcase
  end

  // Moore outputs. Any illegal code decodes to all motor outputs low.
  assign MOTOR1    = (st == S_ELECTRICO);
  assign MOTOR2    = (st == S_GAS);
  assign CARGA_ACK = (st == S_CARGA);
  assign AGOTADO   = (st == S_AGOTADO);
  assign NIVEL_BAT = bat;
  assign NIVEL_TQ  = tq;
  assign ESTADO    = st;

endmodule

// File: tb/tb_gestor_motores.sv
module tb_gestor_motores;

  localparam int W = 6;

  logic         CLK = 1'b0;
  logic         REINICIO = 1'b1;
  logic         ARRANQUE = 1'b0;
  logic         MODO = 1'b0;
  logic         PARO = 1'b0;
  logic         CARGA_REQ = 1'b0;
  logic         MOTOR1, MOTOR2, CARGA_ACK, AGOTADO;
  logic [W-1:0] NIVEL_BAT, NIVEL_TQ;
  logic [2:0]   ESTADO;

  int errors = 0;
  int checks = 0;

  gestor_motores #(.BAT_MAX(20), .TQ_MAX(15), .W(W)) dut (
    .CLK(CLK), .REINICIO(REINICIO), .ARRANQUE(ARRANQUE), .MODO(MODO),
    .PARO(PARO), .CARGA_REQ(CARGA_REQ), .MOTOR1(MOTOR1), .MOTOR2(MOTOR2),
    .CARGA_ACK(CARGA_ACK), .AGOTADO(AGOTADO), .NIVEL_BAT(NIVEL_BAT),
    .NIVEL_TQ(NIVEL_TQ), .ESTADO(ESTADO)
  );

  // Clock: 10 time-unit period. Inputs change and outputs are sampled 1 unit
  // after each rising edge.
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    REINICIO = 1'b1;
    tick();
    tick();
    checks++;
    if (ESTADO !== 3'd0 || NIVEL_BAT !== 6'd20 || NIVEL_TQ !== 6'd15) begin
      errors++;
      $display("FAIL reset_state: estado=%0d bat=%0d tq=%0d, required 0/20/15", ESTADO, NIVEL_BAT, NIVEL_TQ);
    end
    checks++;
    if ({MOTOR1, MOTOR2, CARGA_ACK, AGOTADO} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000", {MOTOR1, MOTOR2, CARGA_ACK, AGOTADO});
    end
    REINICIO = 1'b0;
    tick();
    checks++;
    if (ESTADO !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle: estado=%0d, required 0", ESTADO);
    end
  endtask

  task automatic test_full_run();
    MODO = 1'b0;
    ARRANQUE = 1'b1;
    tick();
    ARRANQUE = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      checks++;
      if (ESTADO !== 3'd1 || MOTOR1 !== 1'b1 || MOTOR2 !== 1'b0 || NIVEL_BAT !== 6'(20 - i)) begin
        errors++;
        $display("FAIL elec_run[%0d]: estado=%0d m1=%b m2=%b bat=%0d, required 1/1/0/%0d", i, ESTADO, MOTOR1, MOTOR2, NIVEL_BAT, 20 - i);
      end
      tick();
    end
    for (int i = 0; i <= 15; i++) begin
      checks++;
      if (ESTADO !== 3'd2 || MOTOR2 !== 1'b1 || MOTOR1 !== 1'b0 || NIVEL_TQ !== 6'(15 - i) || NIVEL_BAT !== 6'(i / 4)) begin
        errors++;
        $display("FAIL gas_run[%0d]: estado=%0d m2=%b m1=%b tq=%0d bat=%0d, required 2/1/0/%0d/%0d", i, ESTADO, MOTOR2, MOTOR1, NIVEL_TQ, NIVEL_BAT, 15 - i, i / 4);
      end
      tick();
    end
    for (int i = 0; i <= 4; i++) begin
      checks++;
      if (ESTADO !== 3'd1 || MOTOR1 !== 1'b1 || NIVEL_BAT !== 6'(4 - i) || NIVEL_TQ !== 6'd0) begin
        errors++;
        $display("FAIL elec_regen[%0d]: estado=%0d m1=%b bat=%0d tq=%0d, required 1/1/%0d/0", i, ESTADO, MOTOR1, NIVEL_BAT, NIVEL_TQ, 4 - i);
      end
      tick();
    end
    checks++;
    if (ESTADO !== 3'd4 || AGOTADO !== 1'b1 || NIVEL_BAT !== 6'd0 || NIVEL_TQ !== 6'd0 || MOTOR1 !== 1'b0) begin
      errors++;
      $display("FAIL agotado_entry: estado=%0d ago=%b bat=%0d tq=%0d m1=%b, required 4/1/0/0/0", ESTADO, AGOTADO, NIVEL_BAT, NIVEL_TQ, MOTOR1);
    end
    ARRANQUE = 1'b1;
    PARO = 1'b1;
    tick();
    tick();
    checks++;
    if (ESTADO !== 3'd4 || NIVEL_BAT !== 6'd0) begin
      errors++;
      $display("FAIL agotado_ignores: estado=%0d bat=%0d, required 4/0", ESTADO, NIVEL_BAT);
    end
    ARRANQUE = 1'b0;
    PARO = 1'b0;
  endtask

  task automatic test_charge();
    CARGA_REQ = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (ESTADO !== 3'd3 || CARGA_ACK !== 1'b1 || NIVEL_BAT !== 6'(i) || NIVEL_TQ !== 6'((i > 15) ? 15 : i)) begin
        errors++;
        $display("FAIL charge[%0d]: estado=%0d ack=%b bat=%0d tq=%0d, required 3/1/%0d/%0d", i, ESTADO, CARGA_ACK, NIVEL_BAT, NIVEL_TQ, i, (i > 15) ? 15 : i);
      end
      tick();
    end
    checks++;
    if (ESTADO !== 3'd0 || CARGA_ACK !== 1'b0 || NIVEL_BAT !== 6'd20 || NIVEL_TQ !== 6'd15) begin
      errors++;
      $display("FAIL charge_done: estado=%0d ack=%b bat=%0d tq=%0d, required 0/0/20/15", ESTADO, CARGA_ACK, NIVEL_BAT, NIVEL_TQ);
    end
    tick();
    tick();
    checks++;
    if (ESTADO !== 3'd0 || CARGA_ACK !== 1'b0) begin
      errors++;
      $display("FAIL charge_no_reenter: estado=%0d ack=%b, required 0/0", ESTADO, CARGA_ACK);
    end
    CARGA_REQ = 1'b0;
  endtask

  task automatic test_gas_paro();
    MODO = 1'b1;
    ARRANQUE = 1'b1;
    tick();
    ARRANQUE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ESTADO !== 3'd2 || MOTOR2 !== 1'b1 || NIVEL_TQ !== 6'(15 - i)) begin
        errors++;
        $display("FAIL gas_pref[%0d]: estado=%0d m2=%b tq=%0d, required 2/1/%0d", i, ESTADO, MOTOR2, NIVEL_TQ, 15 - i);
      end
      tick();
    end
    PARO = 1'b1;
    checks++;
    if (ESTADO !== 3'd2 || NIVEL_TQ !== 6'd10) begin
      errors++;
      $display("FAIL gas_at_paro: estado=%0d tq=%0d, required 2/10", ESTADO, NIVEL_TQ);
    end
    tick();
    checks++;
    if (ESTADO !== 3'd0 || MOTOR2 !== 1'b0 || NIVEL_TQ !== 6'd10 || NIVEL_BAT !== 6'd20) begin
      errors++;
      $display("FAIL gas_stopped: estado=%0d m2=%b tq=%0d bat=%0d, required 0/0/10/20", ESTADO, MOTOR2, NIVEL_TQ, NIVEL_BAT);
    end
    tick();
    tick();
    checks++;
    if (ESTADO !== 3'd0 || NIVEL_TQ !== 6'd10 || NIVEL_BAT !== 6'd20) begin
      errors++;
      $display("FAIL reposo_frozen: estado=%0d tq=%0d bat=%0d, required 0/10/20", ESTADO, NIVEL_TQ, NIVEL_BAT);
    end
    PARO = 1'b0;
  endtask

  task automatic test_charge_priority();
    MODO = 1'b0;
    ARRANQUE = 1'b1;
    tick();
    ARRANQUE = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    PARO = 1'b1;
    tick();
    PARO = 1'b0;
    checks++;
    if (ESTADO !== 3'd0 || NIVEL_BAT !== 6'd10 || NIVEL_TQ !== 6'd10) begin
      errors++;
      $display("FAIL elec_stop_at_10: estado=%0d bat=%0d tq=%0d, required 0/10/10", ESTADO, NIVEL_BAT, NIVEL_TQ);
    end
    CARGA_REQ = 1'b1;
    ARRANQUE = 1'b1;
    tick();
    checks++;
    if (ESTADO !== 3'd3 || CARGA_ACK !== 1'b1 || MOTOR1 !== 1'b0 || MOTOR2 !== 1'b0) begin
      errors++;
      $display("FAIL charge_priority: estado=%0d ack=%b m1=%b m2=%b, required 3/1/0/0", ESTADO, CARGA_ACK, MOTOR1, MOTOR2);
    end
    CARGA_REQ = 1'b0;
    ARRANQUE = 1'b0;
    tick();
    checks++;
    if (ESTADO !== 3'd0 || NIVEL_BAT !== 6'd10 || NIVEL_TQ !== 6'd10) begin
      errors++;
      $display("FAIL charge_abort: estado=%0d bat=%0d tq=%0d, required 0/10/10", ESTADO, NIVEL_BAT, NIVEL_TQ);
    end
  endtask

  task automatic test_async_reset();
    MODO = 1'b1;
    ARRANQUE = 1'b1;
    tick();
    ARRANQUE = 1'b0;
    tick();
    tick();
    checks++;
    if (ESTADO !== 3'd2 || MOTOR2 !== 1'b1 || NIVEL_TQ !== 6'd8) begin
      errors++;
      $display("FAIL pre_reset_gas: estado=%0d m2=%b tq=%0d, required 2/1/8", ESTADO, MOTOR2, NIVEL_TQ);
    end
    #2;
    REINICIO = 1'b1;
    #1;
    checks++;
    if (MOTOR2 !== 1'b0 || ESTADO !== 3'd0 || NIVEL_BAT !== 6'd20 || NIVEL_TQ !== 6'd15) begin
      errors++;
      $display("FAIL async_reset: m2=%b estado=%0d bat=%0d tq=%0d, required 0/0/20/15", MOTOR2, ESTADO, NIVEL_BAT, NIVEL_TQ);
    end
    #1;
    REINICIO = 1'b0;
    tick();
    checks++;
    if (ESTADO !== 3'd0 || NIVEL_BAT !== 6'd20 || NIVEL_TQ !== 6'd15 || MOTOR2 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_edge: estado=%0d bat=%0d tq=%0d m2=%b, required 0/20/15/0", ESTADO, NIVEL_BAT, NIVEL_TQ, MOTOR2);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_charge();
    test_gas_paro();
    test_charge_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
